// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter
//   Shares one external partial-sum memory between two clients.
//   Client 0 is the convolution controller / MAC path. Client 1 is the host
//   preload / readback port. The read port and the write port each have their
//   own arbiter. Client 0 has priority, and client 1 is served after at most
//   MAX_WAIT contended cycles. Client 0 can also lock client 1 out completely.
//
// Ports
//   clk, arst_in         clock, asynchronous active-high reset
//   c0_lock              client 0 exclusive-access request
//   cN_read_req/addr     read request and address (N = 0, 1)
//   cN_read_gnt          read accepted this cycle (combinational)
//   cN_qout/_valid       broadcast read data, plus a per-client valid flag
//   cN_write_req/addr/din write request, address and data
//   cN_write_gnt         write accepted this cycle (combinational)
//   ext_mem_*            external memory pins (1-cycle read latency)
module ext_mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  arst_in,
  input  logic                  c0_lock,
  input  logic                  c0_read_req,
  input  logic [ADDR_WIDTH-1:0] c0_read_addr,
  output logic                  c0_read_gnt,
  output logic [DATA_WIDTH-1:0] c0_qout,
  output logic                  c0_qout_valid,
  input  logic                  c0_write_req,
  input  logic [ADDR_WIDTH-1:0] c0_write_addr,
  input  logic [DATA_WIDTH-1:0] c0_din,
  output logic                  c0_write_gnt,
  input  logic                  c1_read_req,
  input  logic [ADDR_WIDTH-1:0] c1_read_addr,
  output logic                  c1_read_gnt,
  output logic [DATA_WIDTH-1:0] c1_qout,
  output logic                  c1_qout_valid,
  input  logic                  c1_write_req,
  input  logic [ADDR_WIDTH-1:0] c1_write_addr,
  input  logic [DATA_WIDTH-1:0] c1_din,
  output logic                  c1_write_gnt,
  output logic                  ext_mem_read_en,
  output logic [ADDR_WIDTH-1:0] ext_mem_read_addr,
  input  logic [DATA_WIDTH-1:0] ext_mem_qout,
  output logic                  ext_mem_write_en,
  output logic [ADDR_WIDTH-1:0] ext_mem_write_addr,
  output logic [DATA_WIDTH-1:0] ext_mem_din
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  // Bit 0 is the read port and bit 1 is the write port.
  // While reset is held, requests are masked so that every grant reads 0.
  logic [1:0] req0, req1, gnt0, gnt1;

  assign req0 = {c0_write_req, c0_read_req} & {2{~arst_in}};
  assign req1 = {c1_write_req, c1_read_req} & {2{~arst_in}};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_port
      logic             g0, g1;
      logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

      always_comb begin
        g0         = 1'b0;
        g1         = 1'b0;
        wait_cnt_d = wait_cnt_q;
        if (req0[gi] && req1[gi]) begin
          if (c0_lock) begin
            // Lock wins outright. The counter freezes, so a saturated count
            // gives client 1 the first contended cycle after the unlock.
            g0 = 1'b1;
          end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
            g1         = 1'b1;
            wait_cnt_d = '0;
          end else begin
            g0         = 1'b1;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else if (req0[gi]) begin
          g0 = 1'b1;
        end else if (req1[gi] && !c0_lock) begin
          g1         = 1'b1;
          wait_cnt_d = '0;
        end
      end

      always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) wait_cnt_q <= '0;
        else         wait_cnt_q <= wait_cnt_d;
      end

      assign gnt0[gi] = g0;
      assign gnt1[gi] = g1;
    end
  endgenerate

  assign c0_read_gnt  = gnt0[0];
  assign c1_read_gnt  = gnt1[0];
  assign c0_write_gnt = gnt0[1];
  assign c1_write_gnt = gnt1[1];

  assign ext_mem_read_en  = gnt0[0] | gnt1[0];
  assign ext_mem_write_en = gnt0[1] | gnt1[1];

  // The address and data muxes idle at zero when nothing is granted.
  always_comb begin
    ext_mem_read_addr  = '0;
    ext_mem_write_addr = '0;
    ext_mem_din        = '0;
    if (gnt0[0])      ext_mem_read_addr = c0_read_addr;
    else if (gnt1[0]) ext_mem_read_addr = c1_read_addr;
    if (gnt0[1]) begin
      ext_mem_write_addr = c0_write_addr;
      ext_mem_din        = c0_din;
    end else if (gnt1[1]) begin
      ext_mem_write_addr = c1_write_addr;
      ext_mem_din        = c1_din;
    end
  end

  // Read response tracking. The memory returns data one cycle after read_en,
  // so we remember whether a read was issued and which client issued it.
  logic rd_pending_q, rd_pending_d;
  logic rd_owner_q, rd_owner_d;

  assign rd_pending_d = ext_mem_read_en;
  assign rd_owner_d   = ext_mem_read_en ? gnt1[0] : rd_owner_q;

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign c0_qout       = ext_mem_qout;
  assign c1_qout       = ext_mem_qout;
  assign c0_qout_valid = rd_pending_q && !rd_owner_q;
  assign c1_qout_valid = rd_pending_q &&  rd_owner_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
module tb_ext_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_in;
  logic        c0_lock;
  logic        c0_read_req, c1_read_req, c0_write_req, c1_write_req;
  logic [19:0] c0_read_addr, c1_read_addr, c0_write_addr, c1_write_addr;
  logic [31:0] c0_din, c1_din;
  logic        c0_read_gnt, c1_read_gnt, c0_write_gnt, c1_write_gnt;
  logic [31:0] c0_qout, c1_qout;
  logic        c0_qout_valid, c1_qout_valid;
  logic        ext_mem_read_en, ext_mem_write_en;
  logic [19:0] ext_mem_read_addr, ext_mem_write_addr;
  logic [31:0] ext_mem_qout, ext_mem_din;

  ext_mem_arbiter #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
    .clk(clk), .arst_in(arst_in), .c0_lock(c0_lock),
    .c0_read_req(c0_read_req), .c0_read_addr(c0_read_addr), .c0_read_gnt(c0_read_gnt),
    .c0_qout(c0_qout), .c0_qout_valid(c0_qout_valid),
    .c0_write_req(c0_write_req), .c0_write_addr(c0_write_addr), .c0_din(c0_din),
    .c0_write_gnt(c0_write_gnt),
    .c1_read_req(c1_read_req), .c1_read_addr(c1_read_addr), .c1_read_gnt(c1_read_gnt),
    .c1_qout(c1_qout), .c1_qout_valid(c1_qout_valid),
    .c1_write_req(c1_write_req), .c1_write_addr(c1_write_addr), .c1_din(c1_din),
    .c1_write_gnt(c1_write_gnt),
    .ext_mem_read_en(ext_mem_read_en), .ext_mem_read_addr(ext_mem_read_addr),
    .ext_mem_qout(ext_mem_qout),
    .ext_mem_write_en(ext_mem_write_en), .ext_mem_write_addr(ext_mem_write_addr),
    .ext_mem_din(ext_mem_din)
  );

  // Memory model with a 1-cycle read. A location that has never been written
  // reads as its low address byte, except 0x10, which holds 0xDEADBEEF.
  logic [31:0] mem [0:255];
  bit          written [0:255];
  logic [31:0] mem_q;
  assign ext_mem_qout = mem_q;

  always @(posedge clk) begin
    if (ext_mem_write_en) begin
      mem[ext_mem_write_addr[7:0]]     <= ext_mem_din;
      written[ext_mem_write_addr[7:0]] <= 1'b1;
    end
    if (ext_mem_read_en) begin
      if (written[ext_mem_read_addr[7:0]])   mem_q <= mem[ext_mem_read_addr[7:0]];
      else if (ext_mem_read_addr[7:0] == 8'h10) mem_q <= 32'hDEADBEEF;
      else                                    mem_q <= {24'h0, ext_mem_read_addr[7:0]};
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        lock, r0, r1, w0, w1;
    logic [19:0] ra0, ra1, wa0, wa1;
    logic [31:0] d0, d1;
    logic [3:0]  egnt;   // {c1_write, c0_write, c1_read, c0_read}
    logic [19:0] eraddr, ewaddr;
    logic [31:0] edin;
    logic [1:0]  ev;     // {c1_qout_valid, c0_qout_valid}
    logic        chkq;
    logic [31:0] eq;
  } vec_t;

  function automatic vec_t mk(input logic lock, r0, r1, w0, w1,
                              input logic [19:0] ra0, ra1, wa0, wa1,
                              input logic [31:0] d0, d1,
                              input logic [3:0] egnt,
                              input logic [19:0] eraddr, ewaddr,
                              input logic [31:0] edin,
                              input logic [1:0] ev,
                              input logic chkq,
                              input logic [31:0] eq);
    vec_t v;
    v.lock = lock; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.ra0 = ra0; v.ra1 = ra1; v.wa0 = wa0; v.wa1 = wa1; v.d0 = d0; v.d1 = d1;
    v.egnt = egnt; v.eraddr = eraddr; v.ewaddr = ewaddr; v.edin = edin;
    v.ev = ev; v.chkq = chkq; v.eq = eq;
    return v;
  endfunction

  vec_t tbl [12];

  task automatic drive_idle();
    c0_lock = 0; c0_read_req = 0; c1_read_req = 0; c0_write_req = 0; c1_write_req = 0;
    c0_read_addr = '0; c1_read_addr = '0; c0_write_addr = '0; c1_write_addr = '0;
    c0_din = '0; c1_din = '0;
  endtask

  // One contended cycle on both ports. The caller is just after a rising edge.
  task automatic step(input string tag, input logic lock, input logic exp_c1);
    c0_lock = lock;
    @(negedge clk);
    chk({tag, " rd_gnt"}, {c1_read_gnt, c0_read_gnt},   exp_c1 ? 2'b10 : 2'b01);
    chk({tag, " wr_gnt"}, {c1_write_gnt, c0_write_gnt}, exp_c1 ? 2'b10 : 2'b01);
    $display("%s lock=%0d rd_gnt=%b%b wr_gnt=%b%b", tag, lock,
             c1_read_gnt, c0_read_gnt, c1_write_gnt, c0_write_gnt);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,0,0, 0,0,0,0, 0,0, 4'b0000, 0,0,0, 2'b00, 0,0);
    tbl[1]  = mk(0,1,0,0,0, 20'h100,0,0,0, 0,0, 4'b0001, 20'h100,0,0, 2'b00, 0,0);
    tbl[2]  = mk(0,0,1,0,0, 0,20'h10,0,0, 0,0, 4'b0010, 20'h10,0,0, 2'b01, 0,0);
    tbl[3]  = mk(0,1,1,0,0, 20'h20,20'h10,0,0, 0,0, 4'b0001, 20'h20,0,0, 2'b10, 1,32'hDEADBEEF);
    tbl[4]  = mk(1,0,1,0,0, 0,20'h10,0,0, 0,0, 4'b0000, 0,0,0, 2'b01, 0,0);
    tbl[5]  = mk(0,0,1,1,0, 0,20'h8,20'h4,0, 32'h7,0, 4'b0110, 20'h8,20'h4,32'h7, 2'b00, 0,0);
    tbl[6]  = mk(0,0,0,0,1, 0,0,0,20'h20, 0,32'h55, 4'b1000, 0,20'h20,32'h55, 2'b10, 1,32'h8);
    tbl[7]  = mk(1,0,0,1,1, 0,0,20'h30,20'h31, 32'hA,32'hB, 4'b0100, 0,20'h30,32'hA, 2'b00, 0,0);
    tbl[8]  = mk(1,0,0,0,1, 0,0,0,20'h31, 0,32'hB, 4'b0000, 0,0,0, 2'b00, 0,0);
    tbl[9]  = mk(0,0,0,1,1, 0,0,20'h30,20'h31, 32'hA,32'hB, 4'b0100, 0,20'h30,32'hA, 2'b00, 0,0);
    tbl[10] = mk(0,1,0,0,0, 20'h4,0,0,0, 0,0, 4'b0001, 20'h4,0,0, 2'b00, 0,0);
    tbl[11] = mk(0,0,0,0,0, 0,0,0,0, 0,0, 4'b0000, 0,0,0, 2'b01, 1,32'h7);

    drive_idle();
    arst_in = 1;
    repeat (2) @(posedge clk);
    #1 arst_in = 0;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      c0_lock = tbl[i].lock;
      c0_read_req = tbl[i].r0;  c1_read_req = tbl[i].r1;
      c0_write_req = tbl[i].w0; c1_write_req = tbl[i].w1;
      c0_read_addr = tbl[i].ra0; c1_read_addr = tbl[i].ra1;
      c0_write_addr = tbl[i].wa0; c1_write_addr = tbl[i].wa1;
      c0_din = tbl[i].d0; c1_din = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i),
          {c1_write_gnt, c0_write_gnt, c1_read_gnt, c0_read_gnt}, tbl[i].egnt);
      chk($sformatf("vec%0d rd_en", i), ext_mem_read_en, tbl[i].egnt[0] | tbl[i].egnt[1]);
      chk($sformatf("vec%0d wr_en", i), ext_mem_write_en, tbl[i].egnt[2] | tbl[i].egnt[3]);
      chk($sformatf("vec%0d rd_addr", i), ext_mem_read_addr, tbl[i].eraddr);
      chk($sformatf("vec%0d wr_addr", i), ext_mem_write_addr, tbl[i].ewaddr);
      chk($sformatf("vec%0d din", i), ext_mem_din, tbl[i].edin);
      chk($sformatf("vec%0d qvalid", i), {c1_qout_valid, c0_qout_valid}, tbl[i].ev);
      if (tbl[i].chkq) begin
        chk($sformatf("vec%0d c0_qout", i), c0_qout, tbl[i].eq);
        chk($sformatf("vec%0d c1_qout", i), c1_qout, tbl[i].eq);
      end
      $display("vec %0d gnt=%b qv=%b rd_addr=%h wr_addr=%h din=%h", i,
               {c1_write_gnt, c0_write_gnt, c1_read_gnt, c0_read_gnt},
               {c1_qout_valid, c0_qout_valid}, ext_mem_read_addr, ext_mem_write_addr, ext_mem_din);
    end

    // Reset held with every request active: nothing may be granted
    @(posedge clk); #1;
    arst_in = 1;
    c0_read_req = 1; c1_read_req = 1; c0_write_req = 1; c1_write_req = 1;
    c0_read_addr = 20'h1; c1_read_addr = 20'h2; c0_write_addr = 20'h3; c1_write_addr = 20'h5;
    c0_din = 32'h11; c1_din = 32'h22;
    @(negedge clk);
    chk("rst gnt", {c1_write_gnt, c0_write_gnt, c1_read_gnt, c0_read_gnt}, 4'b0000);
    chk("rst en", {ext_mem_write_en, ext_mem_read_en}, 2'b00);
    chk("rst qvalid", {c1_qout_valid, c0_qout_valid}, 2'b00);
    chk("rst addr", {ext_mem_read_addr, ext_mem_write_addr, ext_mem_din}, 72'h0);
    $display("reset held: gnt=%b", {c1_write_gnt, c0_write_gnt, c1_read_gnt, c0_read_gnt});
    repeat (2) @(posedge clk);
    #1 arst_in = 0;

    // Starvation bound: an 8:1 pattern on both ports, starting in the first cycle after release
    for (int k = 1; k <= 18; k++) step($sformatf("starve%0d", k), 0, (k % 9) == 0);

    // Lock with a saturated counter, then unlock
    for (int k = 1; k <= 8; k++)  step($sformatf("fill%0d", k), 0, 0);
    for (int k = 1; k <= 20; k++) step($sformatf("lock%0d", k), 1, 0);
    step("unlock", 0, 1);
    // Lock with a partial count: the counter must resume from 3, not keep counting
    for (int k = 1; k <= 3; k++) step($sformatf("part%0d", k), 0, 0);
    for (int k = 1; k <= 5; k++) step($sformatf("plock%0d", k), 1, 0);
    for (int k = 1; k <= 5; k++) step($sformatf("resume%0d", k), 0, 0);
    step("resume_c1", 0, 1);

    // Reset in the cycle after a read grant drops the response
    drive_idle();
    @(posedge clk); #1;
    c0_read_req = 1; c0_read_addr = 20'h10;
    @(negedge clk);
    chk("midrd gnt", c0_read_gnt, 1'b1);
    @(posedge clk); #1;
    arst_in = 1; c0_read_req = 0;
    @(negedge clk);
    chk("midrd valid in reset", {c1_qout_valid, c0_qout_valid}, 2'b00);
    $display("mid-read reset asserted: qv=%b", {c1_qout_valid, c0_qout_valid});
    repeat (2) @(posedge clk);
    #1 arst_in = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrd after%0d", k), {c1_qout_valid, c0_qout_valid}, 2'b00);
      $display("after release %0d: qv=%b", k, {c1_qout_valid, c0_qout_valid});
      @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
